nonce_incrementer: RTL and testbench
====================================

Name: nonce_incrementer

Overview:
Multi-cycle 256-bit nonce adder feeding the nonce register's increment path. It captures the current nonce on a start request and adds a fixed stride one CHUNK_W-bit slice per cycle, rippling the carry between slices. It then presents the result with a ready flag, which the nonce register qualifies with its increment request. Chunking keeps the 256-bit carry chain off the critical path of the hash core clock.

Parameters:
CHUNK_W, 32, bits added per cycle; must divide 256; legal values 8, 16, 32, 64, 128, 256.
STRIDE, 1, unsigned constant added per operation (< 2^32); lets N parallel cores walk interleaved nonces.

Ports:
clk_i  input  1  system clock, all logic on rising edge
rst_i  input  1  synchronous active-high reset
start_i  input  1  request: capture nonce_i and begin an add
nonce_i  input  256  current nonce (from the nonce register output)
incremented_nonce_o  output  256  nonce_i + STRIDE, mod 2^256; valid while ready_o=1
ready_o  output  1  result valid; drives the nonce register's ready input
busy_o  output  1  add in progress
wrap_o  output  1  sticky: some completed add overflowed past 2^256-1

Behaviour:
- One clock, synchronous active-high reset; reset is checked before everything else.
- Reset values: state=IDLE, ready_o=0, busy_o=0, wrap_o=0, incremented_nonce_o=0, chunk index=0, carry=0.
- NUM_CHUNKS = 256/CHUNK_W.
- Addend = STRIDE zero-extended to 256 bits.
- States: IDLE, ADD.
- IDLE:
  - On start_i=1: latch nonce_i into the working register, index=0, carry=0, busy_o=1, ready_o=0, go to ADD.
  - Otherwise hold all outputs.
- ADD, each cycle:
  - Compute {c, s} = work[idx] + addend[idx] + carry, width CHUNK_W+1.
  - Write s into work[idx] and set carry=c.
  - If idx=NUM_CHUNKS-1: copy the work register to incremented_nonce_o; if c=1 set wrap_o; busy_o=0, ready_o=1, go to IDLE.
  - Otherwise idx=idx+1.
- Latency: start_i accepted at edge N gives ready_o=1 after edge N+NUM_CHUNKS. Default is 8 cycles; CHUNK_W=256 gives 1 cycle.
- start_i while in ADD: ignored. It is not queued and does not restart the add.
- start_i in the same cycle as ready_o=1: accepted. ready_o drops on the next edge; incremented_nonce_o keeps its old value until the new add completes.
- ready_o stays high until the next accepted start_i or reset. The nonce register may sample it repeatedly; the value does not change.
- Wrap-around: 2^256-1 + 1 gives 0 and sets wrap_o. wrap_o clears only on reset.
- Reset mid-ADD: partial result discarded; all outputs return to reset values on the next edge.
- nonce_i may change during ADD without effect; only the value captured at start is used.

Optional Feature:
Macro NONCE_INCREMENTER_EARLY_DONE_EN.
- Defined:
  - In ADD, when the carry out of the current chunk is 0 and all remaining addend chunks are 0, complete immediately.
  - On completion, copy the work register (upper chunks untouched) to the output and assert ready_o.
  - Latency becomes (index of the terminating chunk)+1 cycles. With STRIDE < 2^CHUNK_W and no carry out of chunk 0, latency is 1.
  - wrap_o is set only when the final chunk produces a carry.
- Undefined: fixed NUM_CHUNKS-cycle latency, as above. Results are bit-identical in both builds; only timing differs.

Test Plan:
1. Reset, then start_i with nonce_i=0 (defaults) -> busy_o high for 8 cycles; then ready_o=1, incremented_nonce_o=1, wrap_o=0.
2. nonce_i=0x...0000_FFFF_FFFF (low 32 bits all ones) -> result 0x1_0000_0000; carry ripples into chunk 1; latency 8 (early-done build: 2).
3. nonce_i=2^256-1 -> result 0, wrap_o=1; wrap_o stays 1 across further adds until rst_i.
4. Pulse start_i twice while busy_o=1 -> ignored; single completion at cycle 8 with the originally captured value. Then start_i coincident with ready_o=1 -> ready_o=0 next cycle, new result 8 cycles later.
5. Assert rst_i at cycle 4 of an add -> next edge: ready_o=0, busy_o=0, incremented_nonce_o=0; a subsequent start completes normally.
6. STRIDE=5, CHUNK_W=8, nonce_i=0xFB -> result 0x100 after 32 cycles; repeat with CHUNK_W=256 -> 1 cycle.

Source files
------------

// File: rtl/nonce_incrementer_if.sv
// Handshake bundle between the nonce register and its chunked incrementer.
// master = nonce register side, slave = incrementer side.
interface nonce_incrementer_if;
   logic         start_i;
   logic [255:0] nonce_i;
   logic [255:0] incremented_nonce_o;
   logic         ready_o;
   logic         busy_o;
   logic         wrap_o;

   modport master (
      output start_i,
      output nonce_i,
      input  incremented_nonce_o,
      input  ready_o,
      input  busy_o,
      input  wrap_o
   );

   modport slave (
      input  start_i,
      input  nonce_i,
      output incremented_nonce_o,
      output ready_o,
      output busy_o,
      output wrap_o
   );
endinterface

// File: rtl/nonce_incrementer.sv
// Multi-cycle 256-bit nonce + STRIDE adder, one CHUNK_W slice per clock.
// Option: NONCE_INCREMENTER_EARLY_DONE_EN ends the add once the carry dies.
module nonce_incrementer #(
   parameter int unsigned CHUNK_W = 32,
   parameter int unsigned STRIDE  = 1
) (
   input logic             clk_i,
   input logic             rst_i,
   nonce_incrementer_if.slave inc
);

   localparam int unsigned NUM_CHUNKS = 256 / CHUNK_W;
   localparam int unsigned IDX_W =
      (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

   typedef logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] vec_t;

   localparam vec_t ADDEND = vec_t'(256'(STRIDE));
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   typedef enum logic {
      IDLE,
      ADD
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   vec_t             work_q, work_d;
   vec_t             result_q, result_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             wrap_q, wrap_d;

   logic [CHUNK_W:0] sum;
   logic             last;
   logic             done;

   assign sum = {1'b0, work_q[idx_q]}
              + {1'b0, ADDEND[idx_q]}
              + {{CHUNK_W{1'b0}}, carry_q};

   assign last = (idx_q == LAST_IDX);

`ifdef NONCE_INCREMENTER_EARLY_DONE_EN
   logic [255:0] addend_rest;
   logic         rest_zero;

   // Addend bits above the chunk being added this cycle.
   assign addend_rest = 256'(ADDEND)
                     >> ((32'(idx_q) + 32'd1) * CHUNK_W);
   assign rest_zero   = (addend_rest == '0);
   assign done        = last | (~sum[CHUNK_W] & rest_zero);
`else
   assign done = last;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         work_q   <= '0;
         result_q <= '0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         work_q   <= work_d;
         result_q <= result_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         wrap_q   <= wrap_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      work_d   = work_q;
      result_d = result_q;
      ready_d  = ready_q;
      busy_d   = busy_q;
      wrap_d   = wrap_q;

      unique case (state_q)
         IDLE: begin
            if (inc.start_i) begin
               work_d  = vec_t'(inc.nonce_i);
               idx_d   = '0;
               carry_d = 1'b0;
               busy_d  = 1'b1;
               ready_d = 1'b0;
               state_d = ADD;
            end
         end
         ADD: begin
            work_d[idx_q] = sum[CHUNK_W-1:0];
            carry_d       = sum[CHUNK_W];
            if (done) begin
               // Untouched upper chunks already hold their final value.
               result_d = work_d;
               wrap_d   = wrap_q | (last & sum[CHUNK_W]);
               busy_d   = 1'b0;
               ready_d  = 1'b1;
               idx_d    = '0;
               state_d  = IDLE;
            end else begin
               idx_d = idx_q + IDX_ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign inc.incremented_nonce_o = 256'(result_q);
   assign inc.ready_o             = ready_q;
   assign inc.busy_o              = busy_q;
   assign inc.wrap_o              = wrap_q;

endmodule

// File: tb/tb_nonce_incrementer.sv
// Randomized bench for nonce_incrementer against a plain-arithmetic model.
// Three instances cover CHUNK_W/STRIDE = 32/1, 8/5 and 256/5.
module tb_nonce_incrementer;

   localparam int NU = 3;
   localparam int CW [NU] = '{32, 8, 256};
   localparam int ST [NU] = '{1, 5, 5};

   typedef struct packed {
      logic         wrap;
      logic         busy;
      logic         ready;
      logic [255:0] res;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks   = 0;
   int failures = 0;

   logic [255:0] prev_res [NU];
   logic         wrap_exp [NU];

   nonce_incrementer_if if0 ();
   nonce_incrementer_if if1 ();
   nonce_incrementer_if if2 ();

   nonce_incrementer #(.CHUNK_W(32), .STRIDE(1)) u0 (
      .clk_i (clk),
      .rst_i (rst),
      .inc   (if0)
   );

   nonce_incrementer #(.CHUNK_W(8), .STRIDE(5)) u1 (
      .clk_i (clk),
      .rst_i (rst),
      .inc   (if1)
   );

   nonce_incrementer #(.CHUNK_W(256), .STRIDE(5)) u2 (
      .clk_i (clk),
      .rst_i (rst),
      .inc   (if2)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive(int u, logic s, logic [255:0] n);
      case (u)
         0: begin if0.start_i = s; if0.nonce_i = n; end
         1: begin if1.start_i = s; if1.nonce_i = n; end
         default: begin if2.start_i = s; if2.nonce_i = n; end
      endcase
   endtask

   function automatic obs_t sample(int u);
      obs_t o;
      case (u)
         0: o = '{if0.wrap_o, if0.busy_o, if0.ready_o,
                  if0.incremented_nonce_o};
         1: o = '{if1.wrap_o, if1.busy_o, if1.ready_o,
                  if1.incremented_nonce_o};
         default: o = '{if2.wrap_o, if2.busy_o, if2.ready_o,
                        if2.incremented_nonce_o};
      endcase
      return o;
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Expected cycles from accepted start to ready.
   function automatic int exp_lat(int u, logic [255:0] n);
      int nc;
      nc = 256 / CW[u];
`ifdef NONCE_INCREMENTER_EARLY_DONE_EN
      for (int k = 0; k < nc; k++) begin
         int m;
         logic [256:0] mask, s, add;
         if (k == nc - 1) return nc;
         m    = (k + 1) * CW[u];
         mask = (257'd1 << m) - 257'd1;
         add  = 257'(ST[u]);
         s    = ({1'b0, n} & mask) + add;
         if (s[m] == 1'b0 && (add >> m) == 257'd0) return k + 1;
      end
`endif
      return nc;
   endfunction

   task automatic check_reset_state();
      for (int u = 0; u < NU; u++) begin
         obs_t o;
         o = sample(u);
         chk($sformatf("rst_ready%0d", u), 256'(o.ready), 256'(0));
         chk($sformatf("rst_busy%0d", u), 256'(o.busy), 256'(0));
         chk($sformatf("rst_wrap%0d", u), 256'(o.wrap), 256'(0));
         chk($sformatf("rst_res%0d", u), o.res, 256'(0));
         prev_res[u] = '0;
         wrap_exp[u] = 1'b0;
      end
   endtask

   // Called at a negedge; leaves the bench at a negedge.
   task automatic op(int u, logic [255:0] n, bit pulse, bit hold);
      logic [256:0] full;
      logic [255:0] exp;
      obs_t o;
      int cyc;
      bit seen;
      full = {1'b0, n} + 257'(ST[u]);
      exp  = full[255:0];
      drive(u, 1'b1, n);
      @(posedge clk);
      @(negedge clk);
      drive(u, 1'b0, rnd256());
      o = sample(u);
      chk("acc_busy", 256'(o.busy), 256'(1));
      chk("acc_ready", 256'(o.ready), 256'(0));
      chk("acc_hold", o.res, prev_res[u]);
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < 400) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         drive(u, 1'b0, rnd256());
         o = sample(u);
         if (o.ready) seen = 1'b1;
         else if (pulse && o.busy && ($urandom % 3 == 0))
            drive(u, 1'b1, rnd256());
      end
      if (!seen) begin
         chk("timeout", 256'(0), 256'(1));
         return;
      end
      wrap_exp[u] = wrap_exp[u] | full[256];
      prev_res[u] = exp;
      chk("latency", 256'(cyc), 256'(exp_lat(u, n)));
      chk("result", o.res, exp);
      chk("wrap", 256'(o.wrap), 256'(wrap_exp[u]));
      chk("done_busy", 256'(o.busy), 256'(0));
      if (hold) begin
         repeat (3) @(negedge clk);
         o = sample(u);
         chk("hold_ready", 256'(o.ready), 256'(1));
         chk("hold_res", o.res, exp);
      end
   endtask

   initial begin
      logic [255:0] ones;
      obs_t o;
      ones = '1;
      for (int u = 0; u < NU; u++) drive(u, 1'b0, '0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset_state();

      op(0, 256'd0, 1'b0, 1'b1);
      op(0, 256'hFFFF_FFFF, 1'b0, 1'b0);
      op(0, ones, 1'b0, 1'b1);
      op(0, rnd256(), 1'b0, 1'b0);
      op(0, rnd256(), 1'b1, 1'b0);
      op(0, rnd256(), 1'b1, 1'b0);

      op(1, 256'hFB, 1'b0, 1'b0);
      op(2, 256'hFB, 1'b0, 1'b0);
      op(1, ones, 1'b0, 1'b0);
      op(2, ones, 1'b0, 1'b0);

      // Reset in the middle of a long rippling add.
      drive(0, 1'b1, {128'd7, {128{1'b1}}});
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, '0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_state();
      o = sample(0);
      chk("post_rst_idle", 256'(o.busy), 256'(0));
      op(0, {128'd7, {128{1'b1}}}, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         int u;
         logic [255:0] n;
         int j;
         u = int'($urandom_range(0, NU - 1));
         n = rnd256();
         j = int'($urandom_range(0, 32));
         if ($urandom % 2 == 0) n = n | ((256'd1 << (8 * j)) - 256'd1);
         if ($urandom % 8 == 0) n = ones;
         op(u, n, bit'($urandom % 2), bit'($urandom % 4 == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
